io_port: RTL

//  Responder end of io_bus: board-side peripheral serving the CPU's IN/OUT instructions.

---
 rtl/io_port_if.sv | 12 +
 rtl/io_port.sv | 85 ++++++++
 2 files changed

// File: rtl/io_port_if.sv
// io_bus responder-side bundle: debounced switch value and pulses toward the CPU,
// CPU LED register value toward the board-side port.
interface io_port_if #(
    parameter int WIDTH = 4
) ();
    logic [WIDTH-1:0] switch;
    logic [WIDTH-1:0] switch_changed;
    logic [WIDTH-1:0] led;

    modport master (input switch, input switch_changed, output led);
    modport slave  (output switch, output switch_changed, input led);
endinterface

// File: rtl/io_port.sv
// Board-side io_bus responder: synchronizes and debounces the raw switch pins for the
// CPU, and registers the CPU LED value onto the board LED pins.
module io_port #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit LED_ACTIVE_LOW  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] switch_raw,
    output logic [WIDTH-1:0] led_pin,
    io_port_if.slave         bus
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [CNT_W-1:0] cnt_q  [WIDTH];
    logic [CNT_W-1:0] cnt_d  [WIDTH];
    logic [WIDTH-1:0] switch_q, switch_d;
    logic [WIDTH-1:0] changed_q, changed_d;
    logic [WIDTH-1:0] led_pin_q, led_pin_d;
    logic [WIDTH-1:0] sync_s;

    assign sync_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d[0] = switch_raw;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // Any return to the accepted value before terminal count throws the count away.
    always_comb begin
        switch_d  = switch_q;
        changed_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_s[i] == switch_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= TERMINAL) begin
                switch_d[i]  = sync_s[i];
                changed_d[i] = 1'b1;
                cnt_d[i]     = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        led_pin_d = LED_ACTIVE_LOW ? ~bus.led : bus.led;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            switch_q  <= '0;
            changed_q <= '0;
            led_pin_q <= LED_ACTIVE_LOW ? '1 : '0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            switch_q  <= switch_d;
            changed_q <= changed_d;
            led_pin_q <= led_pin_d;
        end
    end

    assign bus.switch         = switch_q;
    assign bus.switch_changed = changed_q;
    assign led_pin            = led_pin_q;
endmodule
